// File: rtl/board_cell_registers.sv
// ---------------------------------------------------------------------------
// board_cell_registers
//
// Board-state store for the game datapath. Holds a BOARD_DIM x BOARD_DIM grid
// of 2-bit cell codes (00 empty, 01 player, 10 computer), commits moves via a
// valid/ready handshake, flags illegal moves, supports one-step undo from a
// move-history stack, and clears the board with a one-cell-per-cycle sweep.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   clear_req         start a clear sweep (IDLE only)
//   mv_valid/mv_idx/  move request: target cell (row-major) and mover
//   mv_who            (0 = player, 1 = computer)
//   mv_ready          move can be accepted this cycle (combinational)
//   mv_ack/mv_illegal one-cycle result pulses, one cycle after acceptance
//   undo_req          pop and erase the most recent committed move
//   undo_ack/undo_err one-cycle result pulses for an undo request
//   board             packed cell codes, cell i at bits [2i+1:2i]
//   move_count        number of occupied cells
//   board_full        move_count == CELLS
//   busy              clear sweep in progress
// ---------------------------------------------------------------------------
module board_cell_registers #(
    parameter int BOARD_DIM = 3,
    parameter int IDX_W     = $clog2(BOARD_DIM*BOARD_DIM),
    parameter int CNT_W     = $clog2(BOARD_DIM*BOARD_DIM+1)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               clear_req,
    input  logic                               mv_valid,
    input  logic [IDX_W-1:0]                   mv_idx,
    input  logic                               mv_who,
    output logic                               mv_ready,
    output logic                               mv_ack,
    output logic                               mv_illegal,
    input  logic                               undo_req,
    output logic                               undo_ack,
    output logic                               undo_err,
    output logic [2*BOARD_DIM*BOARD_DIM-1:0]   board,
    output logic [CNT_W-1:0]                   move_count,
    output logic                               board_full,
    output logic                               busy
);

    localparam int CELLS = BOARD_DIM * BOARD_DIM;

    localparam logic [1:0] EMPTY    = 2'b00;
    localparam logic [1:0] PLAYER   = 2'b01;
    localparam logic [1:0] COMPUTER = 2'b10;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [1:0]       cells_q [CELLS];
    logic [1:0]       cells_d [CELLS];
    logic [IDX_W-1:0] hist_q  [CELLS];
    logic [IDX_W-1:0] hist_d  [CELLS];
    // The history pointer always equals the number of occupied cells (every
    // push fills one cell, every pop empties one, a clear resets both), so a
    // single counter serves as both move_count and the stack pointer.
    logic [CNT_W-1:0] count_q, count_d;
    logic             ack_q, ack_d, ill_q, ill_d;
    logic             uack_q, uack_d, uerr_q, uerr_d;

    logic [1:0]       tgt_code;
    logic [IDX_W-1:0] top_idx;
    logic             in_range;

    assign mv_ready = (state_q == S_IDLE) && !clear_req && !undo_req;

    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        cells_d  = cells_q;
        hist_d   = hist_q;
        count_d  = count_q;
        ack_d    = 1'b0;
        ill_d    = 1'b0;
        uack_d   = 1'b0;
        uerr_d   = 1'b0;
        tgt_code = EMPTY;
        top_idx  = '0;
        in_range = (int'(mv_idx) < CELLS);

        // Match-based lookups keep out-of-range indices from ever addressing
        // the arrays directly.
        for (int i = 0; i < CELLS; i++) begin
            if (mv_idx == IDX_W'(i))    tgt_code = cells_q[i];
            if (count_q == CNT_W'(i+1)) top_idx  = hist_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    sweep_d = '0;
                end else if (undo_req) begin
                    if (count_q == '0) begin
                        uerr_d = 1'b1;
                    end else begin
                        for (int i = 0; i < CELLS; i++)
                            if (top_idx == IDX_W'(i)) cells_d[i] = EMPTY;
                        count_d = count_q - 1'b1;
                        uack_d  = 1'b1;
                    end
                end else if (mv_valid) begin
                    if (in_range && tgt_code == EMPTY) begin
                        for (int i = 0; i < CELLS; i++) begin
                            if (mv_idx == IDX_W'(i))
                                cells_d[i] = mv_who ? COMPUTER : PLAYER;
                            if (count_q == CNT_W'(i))
                                hist_d[i] = mv_idx;
                        end
                        count_d = count_q + 1'b1;
                        ack_d   = 1'b1;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                for (int i = 0; i < CELLS; i++)
                    if (sweep_q == IDX_W'(i)) cells_d[i] = EMPTY;
                if (sweep_q == IDX_W'(CELLS-1)) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sweep_q <= '0;
            cells_q <= '{default: EMPTY};
            hist_q  <= '{default: '0};
            count_q <= '0;
            ack_q   <= 1'b0;
            ill_q   <= 1'b0;
            uack_q  <= 1'b0;
            uerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            cells_q <= cells_d;
            hist_q  <= hist_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            ill_q   <= ill_d;
            uack_q  <= uack_d;
            uerr_q  <= uerr_d;
        end
    end

    always_comb begin
        board = '0;
        for (int i = 0; i < CELLS; i++)
            board[2*i +: 2] = cells_q[i];
    end

    assign move_count = count_q;
    assign board_full = (count_q == CNT_W'(CELLS));
    assign busy       = (state_q == S_CLEAR);
    assign mv_ack     = ack_q;
    assign mv_illegal = ill_q;
    assign undo_ack   = uack_q;
    assign undo_err   = uerr_q;

endmodule

// File: tb/tb_board_cell_registers.sv
module tb_board_cell_registers;

    localparam int BOARD_DIM = 3;
    localparam int CELLS     = BOARD_DIM * BOARD_DIM;
    localparam int IDX_W     = $clog2(CELLS);
    localparam int CNT_W     = $clog2(CELLS + 1);

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               clear_req = 1'b0;
    logic               mv_valid = 1'b0;
    logic [IDX_W-1:0]   mv_idx = '0;
    logic               mv_who = 1'b0;
    logic               mv_ready, mv_ack, mv_illegal;
    logic               undo_req = 1'b0;
    logic               undo_ack, undo_err;
    logic [2*CELLS-1:0] board;
    logic [CNT_W-1:0]   move_count;
    logic               board_full, busy;

    board_cell_registers #(.BOARD_DIM(BOARD_DIM)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .mv_valid   (mv_valid),
        .mv_idx     (mv_idx),
        .mv_who     (mv_who),
        .mv_ready   (mv_ready),
        .mv_ack     (mv_ack),
        .mv_illegal (mv_illegal),
        .undo_req   (undo_req),
        .undo_ack   (undo_ack),
        .undo_err   (undo_err),
        .board      (board),
        .move_count (move_count),
        .board_full (board_full),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: cell contents, a queue as the history stack, and the
    // number of sweep cycles still to run.
    int m_cells [CELLS];
    int m_hist [$];
    int m_clear_left;
    int m_ack, m_ill, m_uack, m_uerr;

    typedef struct {
        bit clr, undo, vld;
        int idx;
        bit who;
        int e_ack, e_ill, e_uack, e_uerr;
        int e_cnt;
        int e_board;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_board();
        int b = 0;
        for (int i = 0; i < CELLS; i++) b |= m_cells[i] << (2*i);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CELLS; i++) m_cells[i] = 0;
        m_hist.delete();
        m_clear_left = 0;
        m_ack = 0; m_ill = 0; m_uack = 0; m_uerr = 0;
    endtask

    task automatic model_step(input bit clr, input bit undo, input bit vld,
                              input int idx, input bit who);
        m_ack = 0; m_ill = 0; m_uack = 0; m_uerr = 0;
        if (m_clear_left > 0) begin
            m_cells[CELLS - m_clear_left] = 0;
            m_clear_left--;
            if (m_clear_left == 0) m_hist.delete();
        end else if (clr) begin
            m_clear_left = CELLS;
        end else if (undo) begin
            if (m_hist.size() == 0) m_uerr = 1;
            else begin
                int top;
                top = m_hist.pop_back();
                m_cells[top] = 0;
                m_uack = 1;
            end
        end else if (vld) begin
            if (idx < CELLS && m_cells[idx] == 0) begin
                m_cells[idx] = who ? 2 : 1;
                m_hist.push_back(idx);
                m_ack = 1;
            end else begin
                m_ill = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("mv_ack",     int'(mv_ack),     m_ack);
        chk("mv_illegal", int'(mv_illegal), m_ill);
        chk("undo_ack",   int'(undo_ack),   m_uack);
        chk("undo_err",   int'(undo_err),   m_uerr);
        chk("board",      int'(board),      model_board());
        chk("move_count", int'(move_count), m_hist.size());
        chk("board_full", int'(board_full), int'(m_hist.size() == CELLS));
        chk("busy",       int'(busy),       int'(m_clear_left > 0));
    endtask

    // Called at posedge+1: drive inputs, check mv_ready, clock once, check.
    task automatic cycle(input bit clr, input bit undo, input bit vld,
                         input int idx, input bit who);
        logic [31:0] iv;
        iv        = idx;
        clear_req = clr;
        undo_req  = undo;
        mv_valid  = vld;
        mv_idx    = iv[IDX_W-1:0];
        mv_who    = who;
        #1;
        chk("mv_ready", int'(mv_ready), int'(m_clear_left == 0 && !clr && !undo));
        @(posedge clock);
        #1;
        model_step(clr, undo, vld, idx, who);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_req = 1'b0; undo_req = 1'b0; mv_valid = 1'b0;
        mv_idx = '0; mv_who = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    initial begin
        int nbusy;

        //              clr undo vld idx who ack ill uack uerr cnt board
        tbl[0]  = '{0, 0, 1, 4,  0, 1, 0, 0, 0, 1, 'h00100};
        tbl[1]  = '{0, 0, 1, 4,  1, 0, 1, 0, 0, 1, 'h00100};
        tbl[2]  = '{0, 0, 1, 9,  0, 0, 1, 0, 0, 1, 'h00100};
        tbl[3]  = '{0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 'h00000};
        tbl[4]  = '{0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 'h00000};
        tbl[5]  = '{0, 0, 1, 0,  0, 1, 0, 0, 0, 1, 'h00001};
        tbl[6]  = '{0, 0, 1, 2,  1, 1, 0, 0, 0, 2, 'h00021};
        tbl[7]  = '{0, 0, 1, 8,  0, 1, 0, 0, 0, 3, 'h10021};
        tbl[8]  = '{0, 1, 0, 0,  0, 0, 0, 1, 0, 2, 'h00021};
        tbl[9]  = '{0, 1, 0, 0,  0, 0, 0, 1, 0, 1, 'h00001};
        tbl[10] = '{0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 'h00000};
        tbl[11] = '{0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 'h00000};
        tbl[12] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'h00000};
        tbl[13] = '{0, 0, 1, 15, 1, 0, 1, 0, 0, 0, 'h00000};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].clr, tbl[i].undo, tbl[i].vld, tbl[i].idx, tbl[i].who);
            chk($sformatf("tbl%0d_ack", i),   int'(mv_ack),     tbl[i].e_ack);
            chk($sformatf("tbl%0d_ill", i),   int'(mv_illegal), tbl[i].e_ill);
            chk($sformatf("tbl%0d_uack", i),  int'(undo_ack),   tbl[i].e_uack);
            chk($sformatf("tbl%0d_uerr", i),  int'(undo_err),   tbl[i].e_uerr);
            chk($sformatf("tbl%0d_cnt", i),   int'(move_count), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_board", i), int'(board),      tbl[i].e_board);
        end

        // Fill the whole board alternately, then probe full-board behaviour.
        do_reset();
        for (int i = 0; i < CELLS; i++) cycle(0, 0, 1, i, i[0]);
        chk("full_after_fill", int'(board_full), 1);
        chk("count_after_fill", int'(move_count), CELLS);
        cycle(0, 0, 1, 3, 0);
        chk("move_on_full_illegal", int'(mv_illegal), 1);
        cycle(0, 1, 0, 0, 0);
        chk("undo_on_full", int'(undo_ack), 1);

        // Clear with five cells occupied; hammer inputs during the sweep.
        do_reset();
        cycle(0, 0, 1, 1, 0); cycle(0, 0, 1, 3, 1); cycle(0, 0, 1, 5, 0);
        cycle(0, 0, 1, 7, 1); cycle(0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        nbusy = busy ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom_range(0, 15), 0);
            if (busy) nbusy++;
            else break;
        end
        chk("busy_cycles", nbusy, CELLS);
        chk("board_after_clear", int'(board), 0);
        chk("count_after_clear", int'(move_count), 0);
        cycle(0, 1, 0, 0, 0);
        chk("undo_after_clear", int'(undo_err), 1);

        // clear, undo and move in one IDLE cycle: clear wins, no pulses.
        cycle(0, 0, 1, 6, 1);
        cycle(1, 1, 1, 2, 0);
        chk("clr_wins_busy", int'(busy), 1);
        chk("clr_wins_nopulse", int'(mv_ack | mv_illegal | undo_ack | undo_err), 0);
        clear_req = 0; undo_req = 0; mv_valid = 0;
        for (int k = 0; k < CELLS; k++) cycle(0, 0, 0, 0, 0);

        // Reset asserted part-way through a sweep.
        cycle(0, 0, 1, 5, 0); cycle(0, 0, 1, 8, 1);
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid_sweep_reset_busy", int'(busy), 0);
        chk("mid_sweep_reset_board", int'(board), 0);
        compare_all();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
